// File: rtl/ld3320_bus_master_pkg.sv
// Shared types and constants for the LD3320 parallel register bus master.
// The 3-bit state encoding and phase-timer sizing live here.
package ld3320_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ADDR_SETUP  = 3'd1,
        ADDR_STROBE = 3'd2,
        ADDR_HOLD   = 3'd3,
        DATA_SETUP  = 3'd4,
        DATA_STROBE = 3'd5,
        DATA_HOLD   = 3'd6,
        RECOVER     = 3'd7
    } state_e;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WRB_IDLE = 1'b1;
    localparam logic RDB_IDLE = 1'b1;
    localparam logic A0_IDLE  = 1'b1;

    // clog2(max_cyc), but never narrower than one bit.
    function automatic int timer_width(input int max_cyc);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((int'(1) << i) < max_cyc) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ld3320_bus_master_if.sv
// Request/response handshake between the voice-control FSM and the bus master.
// Master modport is the requester; slave modport is the bus master block.
interface ld3320_bus_master_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface

// File: rtl/ld3320_bus_master.sv
// LD3320 register bus master: one read/write per request, address phase then data phase.
// Latency accept->ready = 2*(SETUP+STROBE+HOLD)+RECOVER+1; req_ready only in IDLE.
module ld3320_bus_master
    import ld3320_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ld3320_bus_master_if.slave  bus,
    inout  wire  [DW-1:0]       P,
    output logic                A0,
    output logic                CSB,
    output logic                WRB,
    output logic                RDB
);

    localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_HR = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int MAXC   = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
    localparam int TW     = timer_width(MAXC);

    typedef logic [TW-1:0] tmr_t;

    localparam tmr_t T_SETUP  = tmr_t'(SETUP_CYC - 1);
    localparam tmr_t T_STROBE = tmr_t'(STROBE_CYC - 1);
    localparam tmr_t T_HOLD   = tmr_t'(HOLD_CYC - 1);
    localparam tmr_t T_REC    = tmr_t'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

    state_e        state_q, state_d;
    tmr_t          timer_q, timer_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          csb_q, csb_d;
    logic          wrb_q, wrb_d;
    logic          rdb_q, rdb_d;
    logic          a0_q, a0_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] pout_q, pout_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_write_q, rsp_write_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic accept;
    logic timer_done;
    logic addr_phase;
    logic data_phase;

    function automatic tmr_t phase_load(input state_e s);
        case (s)
            ADDR_SETUP, DATA_SETUP:   return T_SETUP;
            ADDR_STROBE, DATA_STROBE: return T_STROBE;
            ADDR_HOLD, DATA_HOLD:     return T_HOLD;
            RECOVER:                  return T_REC;
            default:                  return '0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rdata_d     = rdata_q;
        accept      = bus.req_valid && ready_q;
        timer_done  = (timer_q == '0);

        if (state_q != IDLE && !timer_done) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR_SETUP;
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            ADDR_SETUP:  if (timer_done) state_d = ADDR_STROBE;
            ADDR_STROBE: if (timer_done) state_d = ADDR_HOLD;
            ADDR_HOLD:   if (timer_done) state_d = DATA_SETUP;
            DATA_SETUP:  if (timer_done) state_d = DATA_STROBE;
            DATA_STROBE: if (timer_done) state_d = DATA_HOLD;
            DATA_HOLD: begin
                if (timer_done) begin
                    state_d     = (RECOVER_CYC > 0) ? RECOVER : IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = wr_q;
                end
            end
            RECOVER:     if (timer_done) state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        // Chip drives P while RDB is low; capture on the last low cycle.
        if (state_q == DATA_STROBE && timer_done && !wr_q) begin
            rdata_d = P;
        end

        if (state_d != state_q) begin
            timer_d = phase_load(state_d);
        end
    end

    // Pins are decoded from the next state so they switch on the entering edge.
    always_comb begin
        addr_phase = (state_d == ADDR_SETUP) || (state_d == ADDR_STROBE) ||
                     (state_d == ADDR_HOLD);
        data_phase = (state_d == DATA_SETUP) || (state_d == DATA_STROBE) ||
                     (state_d == DATA_HOLD);
        csb_d      = (addr_phase || data_phase) ? 1'b0 : CSB_IDLE;
        a0_d       = data_phase ? 1'b0 : A0_IDLE;
        wrb_d      = ((state_d == ADDR_STROBE) || (state_d == DATA_STROBE && wr_d))
                     ? 1'b0 : WRB_IDLE;
        rdb_d      = (state_d == DATA_STROBE && !wr_d) ? 1'b0 : RDB_IDLE;
        oe_d       = addr_phase || (data_phase && wr_d);
        ready_d    = (state_d == IDLE);
        pout_d     = '0;
        if (addr_phase) begin
            pout_d[AW-1:0] = addr_d;
        end else if (data_phase && wr_d) begin
            pout_d = wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            csb_q       <= CSB_IDLE;
            wrb_q       <= WRB_IDLE;
            rdb_q       <= RDB_IDLE;
            a0_q        <= A0_IDLE;
            oe_q        <= 1'b0;
            pout_q      <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            csb_q       <= csb_d;
            wrb_q       <= wrb_d;
            rdb_q       <= rdb_d;
            a0_q        <= a0_d;
            oe_q        <= oe_d;
            pout_q      <= pout_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rdata_q     <= rdata_d;
        end
    end

    assign P             = oe_q ? pout_q : {DW{1'bz}};
    assign A0            = a0_q;
    assign CSB           = csb_q;
    assign WRB           = wrb_q;
    assign RDB           = rdb_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ld3320_bus_master.sv
// Bench for ld3320_bus_master: two instances (default timing and 2/4/3/0 timing)
// checked every cycle against an offset-based timing model of each transfer.
`timescale 1ns/1ps
module tb_ld3320_bus_master;

    localparam int DW = 8;
    localparam int AW = 8;

    int ps [2] = '{1, 2};
    int pt [2] = '{2, 4};
    int ph [2] = '{1, 3};
    int pr [2] = '{1, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ld3320_bus_master_if #(.DW(DW), .AW(AW)) ifa ();
    ld3320_bus_master_if #(.DW(DW), .AW(AW)) ifb ();

    wire  [DW-1:0] pa, pb;
    logic a0a, csba, wrba, rdba;
    logic a0b, csbb, wrbb, rdbb;

    logic          tb_oe  [2] = '{1'b1, 1'b1};
    logic [DW-1:0] tb_dat [2] = '{8'h00, 8'h00};
    logic          rv [2] = '{1'b0, 1'b0};
    logic          rw [2] = '{1'b0, 1'b0};
    logic [AW-1:0] ra [2] = '{8'h00, 8'h00};
    logic [DW-1:0] rd [2] = '{8'h00, 8'h00};
    logic [DW-1:0] chip_nxt [2] = '{8'h00, 8'h00};

    assign pa = tb_oe[0] ? tb_dat[0] : 8'bz;
    assign pb = tb_oe[1] ? tb_dat[1] : 8'bz;

    assign ifa.req_valid = rv[0];
    assign ifa.req_write = rw[0];
    assign ifa.req_addr  = ra[0];
    assign ifa.req_wdata = rd[0];
    assign ifb.req_valid = rv[1];
    assign ifb.req_write = rw[1];
    assign ifb.req_addr  = ra[1];
    assign ifb.req_wdata = rd[1];

    ld3320_bus_master #(.DW(DW), .AW(AW), .SETUP_CYC(1), .STROBE_CYC(2),
                        .HOLD_CYC(1), .RECOVER_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .P(pa),
        .A0(a0a), .CSB(csba), .WRB(wrba), .RDB(rdba));

    ld3320_bus_master #(.DW(DW), .AW(AW), .SETUP_CYC(2), .STROBE_CYC(4),
                        .HOLD_CYC(3), .RECOVER_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .P(pb),
        .A0(a0b), .CSB(csbb), .WRB(wrbb), .RDB(rdbb));

    // Model: the transfer in flight is fully described by its accept cycle.
    bit            cur_v    [2] = '{1'b0, 1'b0};
    int            cur_k    [2] = '{0, 0};
    bit            cur_wr   [2] = '{1'b0, 1'b0};
    logic [AW-1:0] cur_addr [2] = '{8'h00, 8'h00};
    logic [DW-1:0] cur_wd   [2] = '{8'h00, 8'h00};
    logic [DW-1:0] cur_chip [2] = '{8'h00, 8'h00};
    logic [DW-1:0] exp_rdata[2] = '{8'h00, 8'h00};

    typedef struct packed {
        logic          csb;
        logic          a0;
        logic          wrb;
        logic          rdb;
        logic          oe;
        logic [DW-1:0] pval;
        logic          ready;
    } pins_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ofs(input int d);
        return cur_v[d] ? (cyc - cur_k[d]) : -1;
    endfunction

    function automatic pins_t model_pins(input int d, input int o);
        pins_t e;
        int    s  = ps[d];
        int    t  = pt[d];
        int    ph_len = ps[d] + pt[d] + ph[d];
        e.csb   = 1'b1;
        e.a0    = 1'b1;
        e.wrb   = 1'b1;
        e.rdb   = 1'b1;
        e.oe    = 1'b0;
        e.pval  = '0;
        e.ready = (o <= 0) || (o >= 2 * ph_len + pr[d] + 1);
        if (o >= 1 && o <= ph_len) begin
            e.csb  = 1'b0;
            e.oe   = 1'b1;
            e.pval = cur_addr[d];
            if (o > s && o <= s + t) e.wrb = 1'b0;
        end else if (o > ph_len && o <= 2 * ph_len) begin
            e.csb  = 1'b0;
            e.a0   = 1'b0;
            e.oe   = cur_wr[d];
            e.pval = cur_wd[d];
            if (o - ph_len > s && o - ph_len <= s + t) begin
                if (cur_wr[d]) e.wrb = 1'b0;
                else           e.rdb = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check_dut(input int d, input logic csb, a0, wrb, rdb,
                             input logic [DW-1:0] p, input logic ready, rvld, rwr,
                             input logic [DW-1:0] rdata, input logic vld, wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        pins_t e;
        int    o;
        int    ph_len;
        bit    exp_rv;
        if (!rst_n) begin
            cur_v[d]     = 1'b0;
            exp_rdata[d] = '0;
            chk("rst_csb", csb, 1);
            chk("rst_wrb", wrb, 1);
            chk("rst_rdb", rdb, 1);
            chk("rst_a0", a0, 1);
            chk("rst_rsp_valid", rvld, 0);
            chk("rst_rsp_write", rwr, 0);
            chk("rst_rdata", rdata, 0);
            return;
        end
        o      = ofs(d);
        e      = model_pins(d, o);
        ph_len = ps[d] + pt[d] + ph[d];
        chk("csb", csb, e.csb);
        chk("a0", a0, e.a0);
        chk("wrb", wrb, e.wrb);
        chk("rdb", rdb, e.rdb);
        chk("p_bus", p, e.oe ? e.pval : tb_dat[d]);
        chk("strobe_exclusive", wrb | rdb, 1);
        chk("csb_during_strobe", (!wrb || !rdb) ? csb : 1'b0, 0);
        chk("req_ready", ready, e.ready);
        exp_rv = cur_v[d] && (o == 2 * ph_len + 1);
        chk("rsp_valid", rvld, exp_rv);
        if (exp_rv) begin
            chk("rsp_write", rwr, cur_wr[d]);
            if (!cur_wr[d]) exp_rdata[d] = cur_chip[d];
        end
        if (!(cur_v[d] && !cur_wr[d] && o > ph_len + ps[d] + pt[d] && o <= 2 * ph_len)) begin
            chk("rsp_rdata", rdata, exp_rdata[d]);
        end
        if (vld && e.ready) begin
            cur_v[d]    = 1'b1;
            cur_k[d]    = cyc;
            cur_wr[d]   = wr;
            cur_addr[d] = addr;
            cur_wd[d]   = wdata;
            cur_chip[d] = chip_nxt[d];
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_v[0] = 1'b0;
            cur_v[1] = 1'b0;
        end
        if (!clk) begin
            check_dut(0, csba, a0a, wrba, rdba, pa, ifa.req_ready, ifa.rsp_valid,
                      ifa.rsp_write, ifa.rsp_rdata, rv[0], rw[0], ra[0], rd[0]);
            check_dut(1, csbb, a0b, wrbb, rdbb, pb, ifb.req_ready, ifb.rsp_valid,
                      ifb.rsp_write, ifb.rsp_rdata, rv[1], rw[1], ra[1], rd[1]);
        end
    end

    // Bench side of P: chip data while RDB is low, a random pattern whenever
    // the DUT should have released the bus, nothing while the DUT drives.
    always @(posedge clk or negedge rst_n) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            pins_t e;
            e         = model_pins(d, ofs(d));
            tb_oe[d]  = !e.oe;
            tb_dat[d] = (!e.rdb) ? cur_chip[d] : 8'($urandom);
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction

    function automatic logic rspv(input int d);
        return (d == 0) ? ifa.rsp_valid : ifb.rsp_valid;
    endfunction

    task automatic issue(input int d, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] chip,
                         input bit hold, output int k, output logic rv_at);
        chip_nxt[d] = chip;
        rw[d]       = wr;
        ra[d]       = addr;
        rd[d]       = wdata;
        rv[d]       = 1'b1;
        k           = -1;
        rv_at       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy(d)) begin
                k     = cyc;
                rv_at = rspv(d);
                break;
            end
        end
        if (k < 0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut %0d never raised req_ready within 100 cycles", d);
        end
        @(posedge clk);
        #2;
        if (!hold) rv[d] = 1'b0;
    endtask

    // Hand-computed expectations for the default-timing instance.
    task automatic lit_default(input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] val, input int k);
        for (int o = 1; o <= 10; o++) begin
            @(negedge clk);
            chk("lit_cycle", cyc, k + o);
            if (o <= 4) begin
                chk("lit_addr_a0", a0a, 1);
                chk("lit_addr_p", pa, addr);
                chk("lit_addr_wrb", wrba, (o == 2 || o == 3) ? 0 : 1);
                chk("lit_addr_rdb", rdba, 1);
            end else if (o <= 8) begin
                chk("lit_data_a0", a0a, 0);
                chk("lit_data_wrb", wrba, (wr && (o == 6 || o == 7)) ? 0 : 1);
                chk("lit_data_rdb", rdba, (!wr && (o == 6 || o == 7)) ? 0 : 1);
                if (wr || o == 6 || o == 7) chk("lit_data_p", pa, val);
            end else if (o == 9) begin
                chk("lit_rsp_valid", ifa.rsp_valid, 1);
                chk("lit_rsp_write", ifa.rsp_write, wr);
                if (!wr) chk("lit_rsp_rdata", ifa.rsp_rdata, val);
            end else begin
                chk("lit_ready", ifa.req_ready, 1);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic random_traffic(input int d, input int n);
        int   k;
        logic rva;
        bit   hold;
        int   gap;
        for (int i = 0; i < n; i++) begin
            hold = 1'($urandom_range(0, 1));
            gap  = hold ? 0 : $urandom_range(0, 3);
            issue(d, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                  hold, k, rva);
            repeat (gap) begin
                @(posedge clk);
                #2;
            end
        end
        rv[d] = 1'b0;
    endtask

    initial begin
        int   k, k1, k2, lows;
        logic rva, rva2;
        #6 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(0, 1'b1, 8'h17, 8'h5A, 8'h00, 1'b0, k, rva);
        lit_default(1'b1, 8'h17, 8'h5A, k);
        issue(0, 1'b0, 8'hBA, 8'h00, 8'hC3, 1'b0, k, rva);
        lit_default(1'b0, 8'hBA, 8'hC3, k);

        // Reset in the first data-strobe cycle of a write.
        issue(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, k, rva);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_wrb", wrba, 0);
        rst_n = 1'b0;
        #2;
        chk("reset_wrb", wrba, 1);
        chk("reset_csb", csba, 1);
        chk("reset_p_released", pa, tb_dat[0]);
        chk("reset_rsp_valid", ifa.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(0, 1'b0, 8'h42, 8'h00, 8'h6D, 1'b0, k, rva);
        lit_default(1'b0, 8'h42, 8'h6D, k);

        random_traffic(0, 30);

        // Long-timing instance: write then read with req_valid held.
        issue(1, 1'b1, 8'h55, 8'h99, 8'h00, 1'b1, k1, rva);
        issue(1, 1'b0, 8'h66, 8'h00, 8'h7E, 1'b0, k2, rva2);
        chk("b2b_accept_spacing", k2 - k1, 19);
        chk("b2b_rsp_at_accept", rva2, 1);
        lows = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (!rdbb) lows++;
        end
        chk("b2b_rdb_width", lows, 4);
        chk("b2b_rdata", ifb.rsp_rdata, 8'h7E);
        @(posedge clk);
        #2;

        random_traffic(1, 15);

        repeat (30) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ld3320_bus_master.md
Name: ld3320_bus_master

Overview:
- Parametrised master for the LD3320 voice chip's parallel register bus (A0/CSB/WRB/RDB plus bidirectional data bus P).
- Accepts one register read or write per ready/valid request and runs the two-phase transfer: an address phase (A0=1), then a data phase (A0=0).
- Setup, strobe, hold and recovery durations are parameters, so the block can meet chip timing at any system clock.
- Sits between the voice-control FSM (initialisation, ASR/MP3 sequencing) and the chip pins; the read response carries the sampled byte.

Parameters:
- DW, 8, data bus and register data width.
- AW, 8, register address width; must be <= DW, and the address is driven on P[AW-1:0] with upper bits 0.
- SETUP_CYC, 1, cycles CSB is low and A0/P are stable before the strobe falls; minimum 1.
- STROBE_CYC, 2, cycles WRB or RDB is held low; minimum 1.
- HOLD_CYC, 1, cycles CSB stays low and A0/P stay stable after the strobe rises; minimum 1.
- RECOVER_CYC, 1, idle/turnaround cycles after each transfer with the bus released; 0 skips RECOVER.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a transfer is accepted when req_valid && req_ready
- req_write  in  1  1 = register write, 0 = register read
- req_addr  in  AW  register address
- req_wdata  in  DW  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at transfer completion (reads and writes)
- rsp_write  out  1  direction of the completed transfer; valid with rsp_valid
- rsp_rdata  out  DW  read data; updated only by reads and held until the next read completes
- P  inout  DW  chip data bus
- A0  out  1  1 = address phase, 0 = data phase
- CSB  out  1  chip select, active low
- WRB  out  1  write strobe, active low
- RDB  out  1  read strobe, active low

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - state = IDLE; CSB=WRB=RDB=1, A0=1.
  - P released (Z); rsp_valid=0, rsp_write=0, rsp_rdata=0, internal latches=0.
  - A transfer interrupted by reset is abandoned; no rsp_valid is produced for it.
- Request handling: on acceptance, req_write/req_addr/req_wdata are latched. Request inputs are don't-care until req_ready returns.
- States: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, RECOVER.
- Phase timer:
  - Loaded with N-1 on entry to each timed state, where N is that state's parameter.
  - Decrements each cycle; the FSM advances when the timer is 0.
  - Counter width is clog2 of the largest parameter (at least 1 bit).
- Transitions: IDLE -(accept)-> ADDR_SETUP -> ADDR_STROBE -> ADDR_HOLD -> DATA_SETUP -> DATA_STROBE -> DATA_HOLD -> RECOVER (or IDLE if RECOVER_CYC=0) -> IDLE.
- Pin values per state:
  - IDLE, RECOVER: CSB=1, WRB=1, RDB=1, A0=1.
  - ADDR_SETUP, ADDR_HOLD: CSB=0, A0=1, strobes high.
  - ADDR_STROBE: CSB=0, A0=1, WRB=0.
  - DATA_SETUP, DATA_HOLD: CSB=0, A0=0, strobes high.
  - DATA_STROBE: CSB=0, A0=0, and WRB=0 for a write or RDB=0 for a read.
  - All pin outputs come from flops decoded from next_state, so they are glitch-free and change on the clock edge that enters the state.
- Bus drive:
  - P driven with the address in the three ADDR_* states.
  - P driven with the write data in the DATA_* states of a write.
  - P released (Z) in IDLE, RECOVER and all DATA_* states of a read.
  - WRB and RDB are never low in the same cycle.
- Read sampling: P is registered into rsp_rdata on the final DATA_STROBE cycle, i.e. the cycle before RDB rises.
- Completion: rsp_valid pulses for exactly one cycle, the first cycle after DATA_HOLD (first RECOVER cycle, or the IDLE cycle when RECOVER_CYC=0), with rsp_write set to the completed transfer's direction.
- Latency: accept to the next req_ready = 2*(SETUP_CYC+STROBE_CYC+HOLD_CYC)+RECOVER_CYC+1 cycles. With defaults this is 10 cycles, giving back-to-back throughput of one transfer per 10 cycles.
- Boundary cases:
  - req_valid held high continuously: a new transfer is accepted on the first IDLE cycle.
  - RECOVER_CYC=0: rsp_valid and req_ready are high together, so the next request can be accepted in the same cycle rsp_valid pulses.

Decomposition:
- Package ld3320_pkg:
  - state enum (8 states, 3-bit encoding);
  - function for the timer width;
  - pin idle-level constants (CSB/WRB/RDB/A0 = 1).
- Single module; the phase timer and tristate enable are internal. No sub-module is warranted.

Test Plan:
- Defaults, write addr 0x17 data 0x5A accepted at cycle k:
  - cycles k+1..k+4: A0=1, P=0x17, WRB=0 in k+2..k+3;
  - cycles k+5..k+8: A0=0, P=0x5A, WRB=0 in k+6..k+7;
  - cycle k+9: rsp_valid=1, rsp_write=1; req_ready=1 at k+10.
- Defaults, read addr 0xBA with the model driving 0xC3 while RDB=0:
  - RDB=0 in k+6..k+7 and P is Z from k+5;
  - rsp_valid with rsp_rdata=0xC3 at k+9; RDB stays high throughout the address phase.
- SETUP_CYC=2, STROBE_CYC=4, HOLD_CYC=3, RECOVER_CYC=0, back-to-back write then read with req_valid held:
  - each strobe is 4 cycles wide; the second accept coincides with the first rsp_valid;
  - accept spacing = 19 cycles.
- Assert rst_n low during the DATA_STROBE of a write:
  - within the same cycle WRB=1, CSB=1, P=Z, with no rsp_valid;
  - after release, a fresh read completes normally.
- Continuous checkers across random traffic:
  - never WRB=0 and RDB=0 together;
  - P never driven while RDB=0;
  - CSB=0 throughout every strobe;
  - rsp_rdata unchanged by writes.
